// File: rtl/writeback_stage_if.sv
// Bundle of the memory-to-writeback bus, pipeline controls and writeback outputs.
//   master : drives the M-stage payload and controls, observes writeback results
//   slave  : the writeback stage itself
interface writeback_stage_if;
    logic [31:0] alu_result_m_i;
    logic [31:0] reduced_data_m_i;
    logic [31:0] pc_target_m_i;
    logic [31:0] pc_plus4_m_i;
    logic [31:0] imm_ext_m_i;
    logic [4:0]  rd_m_i;
    logic [2:0]  result_src_m_i;
    logic        reg_write_m_i;
    logic        valid_m_i;
    logic        stall_w_i;
    logic        flush_w_i;
    logic        cnt_clr_i;
    logic        cnt_inhibit_i;
    logic [31:0] result_w_o;
    logic [4:0]  rd_w_o;
    logic        reg_write_w_o;
    logic        retire_w_o;
    logic [63:0] mcycle_o;
    logic [63:0] minstret_o;

    modport master (
        output alu_result_m_i, reduced_data_m_i, pc_target_m_i, pc_plus4_m_i,
               imm_ext_m_i, rd_m_i, result_src_m_i, reg_write_m_i, valid_m_i,
               stall_w_i, flush_w_i, cnt_clr_i, cnt_inhibit_i,
        input  result_w_o, rd_w_o, reg_write_w_o, retire_w_o, mcycle_o, minstret_o
    );

    modport slave (
        input  alu_result_m_i, reduced_data_m_i, pc_target_m_i, pc_plus4_m_i,
               imm_ext_m_i, rd_m_i, result_src_m_i, reg_write_m_i, valid_m_i,
               stall_w_i, flush_w_i, cnt_clr_i, cnt_inhibit_i,
        output result_w_o, rd_w_o, reg_write_w_o, retire_w_o, mcycle_o, minstret_o
    );
endinterface

// File: rtl/writeback_stage.sv
// Writeback pipeline stage: W register, result select, write strobe, retire
// pulse and the mcycle/minstret counters.
//   clk_i   : clock, rising edge
//   reset_i : synchronous active-low reset
//   bus     : M-stage payload, stall/flush, counter controls and W outputs
module writeback_stage (
    input  logic              clk_i,
    input  logic              reset_i,
    writeback_stage_if.slave  bus
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;
    localparam int unsigned SRC_W = 3;
    localparam int unsigned CNT_W = 64;

    // Result-select encodings shared with the control unit
    localparam logic [SRC_W-1:0] RESULT_ALU      = 3'b000;
    localparam logic [SRC_W-1:0] RESULT_MEM      = 3'b001;
    localparam logic [SRC_W-1:0] RESULT_PCTARGET = 3'b010;
    localparam logic [SRC_W-1:0] RESULT_PCPLUS4  = 3'b011;
    localparam logic [SRC_W-1:0] RESULT_IMM      = 3'b100;

    logic [XLEN-1:0]  r_alu_result_w;
    logic [XLEN-1:0]  r_reduced_data_w;
    logic [XLEN-1:0]  r_pc_target_w;
    logic [XLEN-1:0]  r_pc_plus4_w;
    logic [XLEN-1:0]  r_imm_ext_w;
    logic [REG_W-1:0] r_rd_w;
    logic [SRC_W-1:0] r_result_src_w;
    logic             r_reg_write_w;
    logic             r_valid_w;
    logic [CNT_W-1:0] r_mcycle;
    logic [CNT_W-1:0] r_minstret;

    logic [XLEN-1:0]  w_result;
    logic             w_retire;

    // W pipeline register; flush only kills the strobes, payload is don't-care
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            r_alu_result_w   <= '0;
            r_reduced_data_w <= '0;
            r_pc_target_w    <= '0;
            r_pc_plus4_w     <= '0;
            r_imm_ext_w      <= '0;
            r_rd_w           <= '0;
            r_result_src_w   <= '0;
            r_reg_write_w    <= 1'b0;
            r_valid_w        <= 1'b0;
        end else if (bus.flush_w_i) begin
            r_reg_write_w    <= 1'b0;
            r_valid_w        <= 1'b0;
        end else if (!bus.stall_w_i) begin
            r_alu_result_w   <= bus.alu_result_m_i;
            r_reduced_data_w <= bus.reduced_data_m_i;
            r_pc_target_w    <= bus.pc_target_m_i;
            r_pc_plus4_w     <= bus.pc_plus4_m_i;
            r_imm_ext_w      <= bus.imm_ext_m_i;
            r_rd_w           <= bus.rd_m_i;
            r_result_src_w   <= bus.result_src_m_i;
            r_reg_write_w    <= bus.reg_write_m_i;
            r_valid_w        <= bus.valid_m_i;
        end
    end

    // Result select; unknown codes write zero
    always_comb begin
        w_result = '0;
        case (r_result_src_w)
            RESULT_ALU:      w_result = r_alu_result_w;
            RESULT_MEM:      w_result = r_reduced_data_w;
            RESULT_PCTARGET: w_result = r_pc_target_w;
            RESULT_PCPLUS4:  w_result = r_pc_plus4_w;
            RESULT_IMM:      w_result = r_imm_ext_w;
            default:         w_result = '0;
        endcase
    end

    // An instruction retires only in its last W cycle; reset masks the
    // strobes so a held instruction can never leak out while reset is low
    assign w_retire = reset_i & r_valid_w & ~bus.stall_w_i;

    // Performance counters; clear beats inhibit, both wrap silently
    always_ff @(posedge clk_i) begin
        if (!reset_i || bus.cnt_clr_i) begin
            r_mcycle   <= '0;
            r_minstret <= '0;
        end else if (!bus.cnt_inhibit_i) begin
            r_mcycle <= r_mcycle + CNT_W'(1);
            if (w_retire) begin
                r_minstret <= r_minstret + CNT_W'(1);
            end
        end
    end

    assign bus.result_w_o    = reset_i ? w_result : '0;
    assign bus.rd_w_o        = r_rd_w;
    assign bus.reg_write_w_o = w_retire & r_reg_write_w;
    assign bus.retire_w_o    = w_retire;
    assign bus.mcycle_o      = r_mcycle;
    assign bus.minstret_o    = r_minstret;
endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: reset, writeback, stall, flush, result
// select, counter inhibit/clear/wrap and reset during a stall.
module tb_writeback_stage;
    localparam logic [2:0] RESULT_ALU      = 3'b000;
    localparam logic [2:0] RESULT_MEM      = 3'b001;
    localparam logic [2:0] RESULT_PCTARGET = 3'b010;
    localparam logic [2:0] RESULT_PCPLUS4  = 3'b011;
    localparam logic [2:0] RESULT_IMM      = 3'b100;

    logic        clk;
    logic        rst_n;
    logic [63:0] exp_mc;
    int          n_checks;
    int          n_pass;

    writeback_stage_if bus ();

    writeback_stage dut (
        .clk_i   (clk),
        .reset_i (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // One clock; exp_mc follows the counter rules from the bench's own inputs
    task automatic tick();
        logic r, c, h;
        r = rst_n;
        c = bus.cnt_clr_i;
        h = bus.cnt_inhibit_i;
        @(posedge clk);
        if (!r || c) exp_mc = '0;
        else if (!h) exp_mc = exp_mc + 64'd1;
        #1;
    endtask

    task automatic set_m(input logic v, input logic rw, input logic [4:0] rd, input logic [2:0] src);
        bus.valid_m_i      = v;
        bus.reg_write_m_i  = rw;
        bus.rd_m_i         = rd;
        bus.result_src_m_i = src;
    endtask

    logic [2:0]  mux_src [6];
    logic [31:0] mux_exp [6];

    initial begin
        n_checks = 0;
        n_pass   = 0;
        exp_mc   = '0;
        mux_src  = '{RESULT_ALU, RESULT_MEM, RESULT_PCTARGET, RESULT_PCPLUS4, RESULT_IMM, 3'b111};
        mux_exp  = '{32'hA1A1_0001, 32'h1234_5678, 32'h0000_2000, 32'h0000_0104, 32'h0000_0ABC, 32'h0};

        rst_n = 1'b0;
        bus.alu_result_m_i   = 32'hA1A1_0001;
        bus.reduced_data_m_i = 32'hDEAD_BEEF;
        bus.pc_target_m_i    = 32'h0000_2000;
        bus.pc_plus4_m_i     = 32'h0000_0104;
        bus.imm_ext_m_i      = 32'h0000_0ABC;
        bus.stall_w_i        = 1'b0;
        bus.flush_w_i        = 1'b0;
        bus.cnt_clr_i        = 1'b0;
        bus.cnt_inhibit_i    = 1'b0;
        set_m(1'b0, 1'b0, 5'd0, RESULT_ALU);

        // Reset state
        tick();
        tick();
        check("rst_result", 64'(bus.result_w_o), 64'h0);
        check("rst_rd", 64'(bus.rd_w_o), 64'h0);
        check("rst_regwr", 64'(bus.reg_write_w_o), 64'h0);
        check("rst_retire", 64'(bus.retire_w_o), 64'h0);
        check("rst_mcycle", bus.mcycle_o, 64'h0);
        check("rst_minstret", bus.minstret_o, 64'h0);

        // Basic load writeback
        rst_n = 1'b1;
        set_m(1'b1, 1'b1, 5'd5, RESULT_MEM);
        tick();
        check("wb_result", 64'(bus.result_w_o), 64'hDEAD_BEEF);
        check("wb_rd", 64'(bus.rd_w_o), 64'd5);
        check("wb_regwr", 64'(bus.reg_write_w_o), 64'd1);
        check("wb_retire", 64'(bus.retire_w_o), 64'd1);
        check("wb_mcycle", bus.mcycle_o, 64'd1);
        set_m(1'b0, 1'b0, 5'd0, RESULT_ALU);
        tick();
        check("wb_minstret", bus.minstret_o, 64'd1);
        check("wb_mcycle2", bus.mcycle_o, exp_mc);

        // Three-cycle stall, single retire afterwards
        set_m(1'b1, 1'b1, 5'd7, RESULT_PCPLUS4);
        tick();
        set_m(1'b0, 1'b0, 5'd0, RESULT_ALU);
        bus.stall_w_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stl_result", 64'(bus.result_w_o), 64'h104);
            check("stl_regwr", 64'(bus.reg_write_w_o), 64'd0);
            check("stl_retire", 64'(bus.retire_w_o), 64'd0);
            tick();
        end
        check("stl_minstret_hold", bus.minstret_o, 64'd1);
        bus.stall_w_i = 1'b0;
        #1;
        check("stl_rel_retire", 64'(bus.retire_w_o), 64'd1);
        check("stl_rel_regwr", 64'(bus.reg_write_w_o), 64'd1);
        check("stl_rel_rd", 64'(bus.rd_w_o), 64'd7);
        tick();
        check("stl_after_retire", 64'(bus.retire_w_o), 64'd0);
        check("stl_minstret", bus.minstret_o, 64'd2);

        // Flush during stall kills the held instruction without a retire
        set_m(1'b1, 1'b1, 5'd9, RESULT_ALU);
        tick();
        bus.stall_w_i = 1'b1;
        bus.flush_w_i = 1'b1;
        #1;
        check("fl_retire_stalled", 64'(bus.retire_w_o), 64'd0);
        tick();
        bus.stall_w_i = 1'b0;
        bus.flush_w_i = 1'b0;
        set_m(1'b0, 1'b0, 5'd0, RESULT_ALU);
        #1;
        check("fl_regwr", 64'(bus.reg_write_w_o), 64'd0);
        check("fl_retire", 64'(bus.retire_w_o), 64'd0);
        check("fl_minstret", bus.minstret_o, 64'd2);

        // Flush while W retires: current instruction still counts
        set_m(1'b1, 1'b1, 5'd10, RESULT_ALU);
        tick();
        set_m(1'b0, 1'b0, 5'd0, RESULT_ALU);
        bus.flush_w_i = 1'b1;
        #1;
        check("flret_retire", 64'(bus.retire_w_o), 64'd1);
        tick();
        bus.flush_w_i = 1'b0;
        #1;
        check("flret_bubble", 64'(bus.retire_w_o), 64'd0);
        check("flret_minstret", bus.minstret_o, 64'd3);

        // Result select over every code plus an illegal one
        bus.reduced_data_m_i = 32'h1234_5678;
        for (int i = 0; i < 6; i++) begin
            set_m(1'b1, 1'b0, 5'd1, mux_src[i]);
            tick();
            check($sformatf("mux_%0d", i), 64'(bus.result_w_o), 64'(mux_exp[i]));
            check($sformatf("mux_regwr_%0d", i), 64'(bus.reg_write_w_o), 64'd0);
        end
        set_m(1'b0, 1'b0, 5'd0, RESULT_ALU);
        tick();
        check("mux_minstret", bus.minstret_o, 64'd9);

        // Inhibit freezes counters but not the pipeline
        bus.cnt_inhibit_i = 1'b1;
        set_m(1'b1, 1'b1, 5'd3, RESULT_IMM);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("inh_retire", 64'(bus.retire_w_o), 64'd1);
            check("inh_result", 64'(bus.result_w_o), 64'h0ABC);
            check("inh_mcycle", bus.mcycle_o, exp_mc);
            check("inh_minstret", bus.minstret_o, 64'd9);
        end
        bus.cnt_inhibit_i = 1'b0;
        set_m(1'b0, 1'b0, 5'd0, RESULT_ALU);
        tick();
        check("inh_rel_minstret", bus.minstret_o, 64'd10);
        check("inh_rel_mcycle", bus.mcycle_o, exp_mc);

        // Counter wrap at all-ones
        set_m(1'b1, 1'b0, 5'd0, RESULT_ALU);
        tick();
        set_m(1'b0, 1'b0, 5'd0, RESULT_ALU);
        dut.r_mcycle   = 64'hFFFF_FFFF_FFFF_FFFF;
        dut.r_minstret = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        check("wrap_mcycle", bus.mcycle_o, 64'h0);
        check("wrap_minstret", bus.minstret_o, 64'h0);
        exp_mc = '0;
        tick();
        check("wrap_next", bus.mcycle_o, 64'd1);

        // Clear beats inhibit
        bus.cnt_clr_i     = 1'b1;
        bus.cnt_inhibit_i = 1'b1;
        tick();
        check("clr_mcycle", bus.mcycle_o, 64'h0);
        check("clr_minstret", bus.minstret_o, 64'h0);
        bus.cnt_clr_i     = 1'b0;
        bus.cnt_inhibit_i = 1'b0;
        tick();
        check("clr_count", bus.mcycle_o, 64'd1);

        // Reset while a valid instruction is stalled
        set_m(1'b1, 1'b1, 5'd12, RESULT_ALU);
        tick();
        bus.stall_w_i = 1'b1;
        set_m(1'b0, 1'b0, 5'd0, RESULT_ALU);
        tick();
        rst_n = 1'b0;
        bus.stall_w_i = 1'b0;
        #1;
        check("rstm_retire", 64'(bus.retire_w_o), 64'd0);
        check("rstm_regwr", 64'(bus.reg_write_w_o), 64'd0);
        check("rstm_result", 64'(bus.result_w_o), 64'h0);
        tick();
        check("rstm_rd", 64'(bus.rd_w_o), 64'd0);
        check("rstm_mcycle", bus.mcycle_o, 64'd0);
        check("rstm_minstret", bus.minstret_o, 64'd0);
        rst_n = 1'b1;
        tick();
        check("rstm_no_retire", 64'(bus.retire_w_o), 64'd0);
        check("rstm_count1", bus.mcycle_o, 64'd1);
        tick();
        check("rstm_count2", bus.mcycle_o, 64'd2);
        check("rstm_minstret_post", bus.minstret_o, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
